// File: rtl/reg_read_pkg.sv
// Shared constants, response entry type and buffer occupancy encodings for the
// register read port.
package reg_read_pkg;

    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 16;
    localparam int SEL_W    = 4;
    localparam int TAG_W    = 4;

    typedef struct packed {
        logic [DATA_W-1:0] rs_data;
        logic [DATA_W-1:0] rt_data;
        logic [TAG_W-1:0]  tag;
    } resp_entry_t;

    typedef enum logic [1:0] {
        CNT_EMPTY = 2'd0,
        CNT_ONE   = 2'd1,
        CNT_FULL  = 2'd2
    } cnt_t;

    // Constant-index mux keeps the slice bounds static for every select value.
    function automatic logic [DATA_W-1:0] select_reg(
        input logic [NUM_REGS*DATA_W-1:0] q,
        input logic [SEL_W-1:0]           sel
    );
        logic [DATA_W-1:0] r;
        r = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (sel == SEL_W'(i)) r = q[i*DATA_W +: DATA_W];
        end
        return r;
    endfunction

endpackage

// File: rtl/reg_read_fifo2.sv
// Two-entry response buffer: 1-bit write/read pointers plus an occupancy
// state machine (EMPTY/ONE/FULL) with valid/ready on both sides.
module reg_read_fifo2
    import reg_read_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        enq_valid,
    output logic        enq_ready,
    input  resp_entry_t enq_data,
    output logic        deq_valid,
    input  logic        deq_ready,
    output resp_entry_t deq_data
);

    cnt_t        count, count_next;
    logic        wr_ptr, rd_ptr;
    resp_entry_t mem [2];
    logic        push, pop;

    assign enq_ready = (count != CNT_FULL);
    assign deq_valid = (count != CNT_EMPTY);
    assign deq_data  = mem[rd_ptr];
    assign push      = enq_valid && enq_ready;
    assign pop       = deq_valid && deq_ready;

    always_comb begin
        count_next = count;
        unique case (count)
            CNT_EMPTY: if (push) count_next = CNT_ONE;
            CNT_ONE: begin
                if (push && !pop)      count_next = CNT_FULL;
                else if (pop && !push) count_next = CNT_EMPTY;
            end
            CNT_FULL:  if (pop) count_next = CNT_ONE;
            default:   count_next = CNT_EMPTY;
        endcase
    end

    // Storage is cleared on reset so an idle port presents all-zero data.
    always_ff @(posedge clk) begin
        if (rst) begin
            count  <= CNT_EMPTY;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            mem[0] <= '0;
            mem[1] <= '0;
        end else begin
            count <= count_next;
            if (push) begin
                mem[wr_ptr] <= enq_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
        end
    end

endmodule

// File: rtl/reg_read_port.sv
// Operand read port: samples two register-bank values at request acceptance and
// queues them in a 2-entry response buffer. Define REG_READ_BYPASS_EN to forward
// a same-cycle bank write into the sampled operands.
module reg_read_port
    import reg_read_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REGS*DATA_W-1:0] reg_q,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [SEL_W-1:0]           req_rs,
    input  logic [SEL_W-1:0]           req_rt,
    input  logic [TAG_W-1:0]           req_tag,
    input  logic                       wr_en,
    input  logic [SEL_W-1:0]           wr_sel,
    input  logic [DATA_W-1:0]          wr_data,
    output logic                       resp_valid,
    input  logic                       resp_ready,
    output logic [DATA_W-1:0]          resp_rs_data,
    output logic [DATA_W-1:0]          resp_rt_data,
    output logic [TAG_W-1:0]           resp_tag
);

    resp_entry_t req_entry, head;

    always_comb begin
        req_entry.rs_data = select_reg(reg_q, req_rs);
        req_entry.rt_data = select_reg(reg_q, req_rt);
        req_entry.tag     = req_tag;
`ifdef REG_READ_BYPASS_EN
        // The bank only shows this write next cycle, so forward it now.
        if (wr_en && (wr_sel == req_rs)) req_entry.rs_data = wr_data;
        if (wr_en && (wr_sel == req_rt)) req_entry.rt_data = wr_data;
`endif
    end

`ifndef REG_READ_BYPASS_EN
    logic unused_wr;
    assign unused_wr = ^{wr_en, wr_sel, wr_data};
`endif

    reg_read_fifo2 u_fifo (
        .clk       (clk),
        .rst       (rst),
        .enq_valid (req_valid),
        .enq_ready (req_ready),
        .enq_data  (req_entry),
        .deq_valid (resp_valid),
        .deq_ready (resp_ready),
        .deq_data  (head)
    );

    assign resp_rs_data = head.rs_data;
    assign resp_rt_data = head.rt_data;
    assign resp_tag     = head.tag;

endmodule

// File: tb/tb_reg_read_port.sv
// Self-checking bench for reg_read_port: a queue-based model of the response
// buffer plus a register array standing in for the bank.
module tb_reg_read_port;
    import reg_read_pkg::*;

    logic                       clk = 1'b0;
    logic                       rst = 1'b1;
    logic [NUM_REGS*DATA_W-1:0] reg_q;
    logic                       req_valid = 1'b0;
    logic                       req_ready;
    logic [SEL_W-1:0]           req_rs = '0;
    logic [SEL_W-1:0]           req_rt = '0;
    logic [TAG_W-1:0]           req_tag = '0;
    logic                       wr_en = 1'b0;
    logic [SEL_W-1:0]           wr_sel = '0;
    logic [DATA_W-1:0]          wr_data = '0;
    logic                       resp_valid;
    logic                       resp_ready = 1'b0;
    logic [DATA_W-1:0]          resp_rs_data;
    logic [DATA_W-1:0]          resp_rt_data;
    logic [TAG_W-1:0]           resp_tag;

    logic [DATA_W-1:0] bank [NUM_REGS];
    resp_entry_t       exp_q[$];
    resp_entry_t       exp_pop[$];
    resp_entry_t       got_pop[$];
    int                checks = 0;
    int                errors = 0;
    logic              last_acc;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) reg_q[i*DATA_W +: DATA_W] = bank[i];
    end

    reg_read_port dut (
        .clk(clk), .rst(rst), .reg_q(reg_q),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_rs(req_rs), .req_rt(req_rt), .req_tag(req_tag),
        .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rs_data(resp_rs_data), .resp_rt_data(resp_rt_data), .resp_tag(resp_tag)
    );

    // Advance one clock: log observed DUT pops and model pops, then update the model.
    task automatic step();
        logic        acc, pop;
        resp_entry_t e;
        e = '0;
        acc = !rst && req_valid && (exp_q.size() < 2);
        pop = !rst && resp_ready && (exp_q.size() != 0);
        if (!rst && resp_valid === 1'b1 && resp_ready)
            got_pop.push_back('{resp_rs_data, resp_rt_data, resp_tag});
        if (pop) exp_pop.push_back(exp_q[0]);
        if (acc) begin
            e.rs_data = bank[req_rs];
            e.rt_data = bank[req_rt];
            e.tag     = req_tag;
`ifdef REG_READ_BYPASS_EN
            if (wr_en && wr_sel == req_rs) e.rs_data = wr_data;
            if (wr_en && wr_sel == req_rt) e.rt_data = wr_data;
`endif
        end
        last_acc = acc;
        @(posedge clk);
        #1;
        if (rst) exp_q.delete();
        else begin
            if (pop) void'(exp_q.pop_front());
            if (acc) exp_q.push_back(e);
        end
        if (wr_en) bank[wr_sel] = wr_data;
    endtask

    task automatic drain();
        req_valid  = 1'b0;
        wr_en      = 1'b0;
        resp_ready = 1'b1;
        repeat (4) step();
    endtask

    task automatic test_reset();
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_flags valid=%b ready=%b expected valid=0 ready=1", resp_valid, req_ready);
        end
        checks++;
        if ({resp_rs_data, resp_rt_data, resp_tag} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_data got rs=%h rt=%h tag=%h expected zero", resp_rs_data, resp_rt_data, resp_tag);
        end
    endtask

    task automatic test_single();
        int pulses = 0;
        bank[3] = 32'h0000_00A5;
        bank[7] = 32'hDEAD_BEEF;
        resp_ready = 1'b1;
        req_valid = 1'b1; req_rs = 4'd3; req_rt = 4'd7; req_tag = 4'd5;
        step();
        req_valid = 1'b0;
        checks++;
        if (resp_valid !== 1'b1 || resp_rs_data !== 32'h0000_00A5 || resp_rt_data !== 32'hDEAD_BEEF || resp_tag !== 4'd5) begin
            errors++;
            $display("[TB] FAIL single_read got v=%b rs=%h rt=%h tag=%h expected v=1 rs=000000a5 rt=deadbeef tag=5",
                     resp_valid, resp_rs_data, resp_rt_data, resp_tag);
        end
        for (int i = 0; i < 4; i++) begin
            if (resp_valid === 1'b1) pulses++;
            step();
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("[TB] FAIL single_pulse got %0d valid cycles expected 1", pulses);
        end
    endtask

    task automatic test_backpressure();
        logic [TAG_W-1:0] tags [3];
        int idx = 0;
        tags[0] = 4'd1; tags[1] = 4'd2; tags[2] = 4'd3;
        resp_ready = 1'b0;
        for (int cyc = 0; cyc < 4 && idx < 3; cyc++) begin
            req_valid = 1'b1;
            req_tag   = tags[idx];
            req_rs    = 4'($urandom);
            req_rt    = 4'($urandom);
            step();
            if (last_acc) idx++;
        end
        checks++;
        if (req_ready !== 1'b0 || resp_valid !== 1'b1 || resp_tag !== 4'd1) begin
            errors++;
            $display("[TB] FAIL bp_full got ready=%b valid=%b tag=%0d expected ready=0 valid=1 tag=1", req_ready, resp_valid, resp_tag);
        end
        resp_ready = 1'b1;
        for (int cyc = 0; cyc < 6 && idx < 3; cyc++) begin
            step();
            if (last_acc) idx++;
        end
        checks++;
        if (idx != 3) begin
            errors++;
            $display("[TB] FAIL bp_accept got %0d accepted expected 3", idx);
        end
        drain();
        checks++;
        if (got_pop.size() != 3 || got_pop[0].tag !== 4'd1 || got_pop[1].tag !== 4'd2 || got_pop[2].tag !== 4'd3) begin
            errors++;
            $display("[TB] FAIL bp_order got %0d responses expected tags 1,2,3", got_pop.size());
        end
    endtask

    task automatic test_stream();
        for (int i = 0; i < NUM_REGS; i++) bank[i] = $urandom;
        resp_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            req_valid = 1'b1;
            req_rs    = 4'(i);
            req_rt    = 4'(15 - i);
            req_tag   = 4'(i);
            step();
            checks++;
            if (resp_valid !== 1'b1 || req_ready !== 1'b1) begin
                errors++;
                $display("[TB] FAIL stream_bubble cycle %0d got valid=%b ready=%b expected 1,1", i, resp_valid, req_ready);
            end
        end
        drain();
    endtask

    task automatic test_bypass();
        logic [DATA_W-1:0] want;
`ifdef REG_READ_BYPASS_EN
        want = 32'h2222_2222;
`else
        want = 32'h1111_1111;
`endif
        bank[4] = 32'h1111_1111;
        resp_ready = 1'b0;
        req_valid = 1'b1; req_rs = 4'd4; req_rt = 4'd4; req_tag = 4'd9;
        wr_en = 1'b1; wr_sel = 4'd4; wr_data = 32'h2222_2222;
        step();
        req_valid = 1'b0; wr_en = 1'b0;
        checks++;
        if (resp_rs_data !== want || resp_rt_data !== want) begin
            errors++;
            $display("[TB] FAIL bypass got rs=%h rt=%h expected %h", resp_rs_data, resp_rt_data, want);
        end
        drain();
    endtask

    task automatic test_simultaneous();
        resp_ready = 1'b0;
        req_valid = 1'b1; req_rs = 4'd1; req_rt = 4'd2; req_tag = 4'd10;
        step();
        resp_ready = 1'b1;
        req_rs = 4'd5; req_rt = 4'd6; req_tag = 4'd11;
        step();
        req_valid = 1'b0; resp_ready = 1'b0;
        checks++;
        if (resp_valid !== 1'b1 || req_ready !== 1'b1 || resp_tag !== 4'd11) begin
            errors++;
            $display("[TB] FAIL simul_pop got valid=%b ready=%b tag=%0d expected 1,1,11", resp_valid, req_ready, resp_tag);
        end
        drain();
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) bank[$urandom_range(0, 15)] = $urandom;
            req_valid  = 1'($urandom_range(0, 1));
            resp_ready = 1'($urandom_range(0, 2) != 0);
            req_rs     = 4'($urandom);
            req_rt     = 4'($urandom);
            req_tag    = 4'($urandom);
            wr_en      = ($urandom_range(0, 2) == 0);
            wr_sel     = ($urandom_range(0, 1) == 0) ? req_rs : 4'($urandom);
            wr_data    = $urandom;
            step();
            checks++;
            if (resp_valid !== (exp_q.size() != 0) || req_ready !== (exp_q.size() < 2)) begin
                errors++;
                $display("[TB] FAIL rand_flags cycle %0d got valid=%b ready=%b expected valid=%b ready=%b",
                         i, resp_valid, req_ready, exp_q.size() != 0, exp_q.size() < 2);
            end
        end
        drain();
    endtask

    task automatic test_reset_mid();
        resp_ready = 1'b0;
        req_valid  = 1'b1;
        req_tag    = 4'd7;
        step();
        step();
        rst = 1'b1; resp_ready = 1'b1;
        step();
        step();
        rst = 1'b0; req_valid = 1'b0; resp_ready = 1'b0;
        test_reset();
        resp_ready = 1'b1;
        step();
        checks++;
        if (resp_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_discard got valid=%b expected 0", resp_valid);
        end
    endtask

    // Compares observed pop stream against the model's and clears both logs.
    task automatic test_pop_log(input string name);
        checks++;
        if (got_pop.size() != exp_pop.size()) begin
            errors++;
            $display("[TB] FAIL %s_count got %0d pops expected %0d", name, got_pop.size(), exp_pop.size());
        end
        for (int i = 0; i < exp_pop.size() && i < got_pop.size(); i++) begin
            checks++;
            if (got_pop[i] !== exp_pop[i]) begin
                errors++;
                $display("[TB] FAIL %s_data #%0d got %h expected %h", name, i, got_pop[i], exp_pop[i]);
            end
        end
        got_pop.delete();
        exp_pop.delete();
    endtask

    initial begin
        for (int i = 0; i < NUM_REGS; i++) bank[i] = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        test_reset();
        test_single();
        test_pop_log("single");
        test_backpressure();
        test_pop_log("backpressure");
        test_stream();
        test_pop_log("stream");
        test_bypass();
        test_pop_log("bypass");
        test_simultaneous();
        test_pop_log("simultaneous");
        test_random();
        test_pop_log("random");
        test_reset_mid();
        got_pop.delete();
        exp_pop.delete();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_read_port.md
# reg_read_port

Read-side companion to the 16 x 32-bit register bank: accepts operand-read requests carrying two register selects (rs, rt) over a valid/ready handshake and returns both 32-bit values through a 2-entry response buffer. It sits between instruction decode and the ALU operand latches. Data is sampled from the bank outputs at acceptance time, with optional same-cycle write forwarding.

## Interface
Parameters:
- DATA_W, 32, register width
- NUM_REGS, 16, registers in the bank
- SEL_W, 4, register select width
- TAG_W, 4, opaque request tag width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- reg_q  in  512  bank outputs packed {q15,...,q0}; q[i] at bits [32i+31:32i]
- req_valid  in  1  request present
- req_ready  out  1  request can be accepted this cycle
- req_rs  in  4  first operand select
- req_rt  in  4  second operand select
- req_tag  in  4  tag returned with response
- wr_en  in  1  bank write this cycle (snoop)
- wr_sel  in  4  register being written
- wr_data  in  32  value being written
- resp_valid  out  1  head response present
- resp_ready  in  1  consumer takes head response
- resp_rs_data  out  32  value of rs
- resp_rt_data  out  32  value of rt
- resp_tag  out  4  tag of head response

## Operation
- Accept = req_valid && req_ready; pop = resp_valid && resp_ready.
- On accept: entry {rs_data, rt_data, tag} written at write pointer; rs_data = q[req_rs], rt_data = q[req_rt] sampled from reg_q in the accept cycle.
- Buffer: 2 entries, 1-bit write pointer, 1-bit read pointer, 2-bit count (0..2); pointers wrap 1 -> 0.
- Count states: EMPTY (0), ONE (1), FULL (2).
  - EMPTY: accept -> ONE.
  - ONE: accept only -> FULL; pop only -> EMPTY; accept and pop -> ONE.
  - FULL: pop -> ONE; accept impossible.
- req_ready = (count != 2); combinational from count only, never from resp_ready.
- resp_valid = (count != 0); outputs show entry at read pointer; stable while resp_valid && !resp_ready.
- req_rs == req_rt legal; both fields carry the same value.
- All 16 selects valid; no error path.

## Timing
- Reset (rst high at a rising edge): count=0, both pointers=0, all entry storage=0 -> resp_valid=0, req_ready=1, resp_rs_data=0, resp_rt_data=0, resp_tag=0.
- Reset wins over simultaneous accept/pop; in-flight entries discarded.
- Latency: request accepted at edge N appears with resp_valid=1 in the cycle after edge N (1 cycle) when buffer was empty.
- Throughput: 1 request/cycle sustained while resp_ready held high.
- With resp_ready low: two accepts fill the buffer, req_ready drops the cycle after the 2nd accept.
- Accept and pop in the same cycle at count=1: head popped, new entry becomes head next cycle, no bubble.

## Configuration
- REG_READ_BYPASS_EN defined: on accept, if wr_en && wr_sel == req_rs, rs_data = wr_data instead of q[req_rs]; same independently for rt. Write in the cycle before accept is not forwarded (bank already shows it).
- Undefined: wr_en/wr_sel/wr_data ignored; data is purely q[sel] at accept (a same-cycle write returns the old value).

## Structure
- Package reg_read_pkg: DATA_W, NUM_REGS, SEL_W, TAG_W constants; resp_entry_t typedef {rs_data, rt_data, tag}; count encodings CNT_EMPTY/CNT_ONE/CNT_FULL.
- Sub-module reg_read_fifo2: 2-entry pointer/count buffer of resp_entry_t with valid/ready both sides; top holds select muxes and bypass logic.

## Test plan
- Reset: assert rst 2 cycles mid-traffic with count=2 -> next cycle resp_valid=0, req_ready=1, all resp data/tag 0.
- Single read: reg_q q3=0x0000_00A5, q7=0xDEAD_BEEF, rs=3, rt=7, tag=5, resp_ready=1 -> one cycle later resp_rs_data=0xA5, resp_rt_data=0xDEADBEEF, tag=5, one pulse.
- Backpressure: resp_ready=0, issue tags 1,2,3 back-to-back -> tags 1,2 accepted, req_ready=0, tag 3 held; raise resp_ready -> order 1,2,3 out, no loss/duplication.
- Streaming: 16 reads rs=i, rt=15-i, resp_ready=1 -> 16 consecutive responses with no bubbles, values match q[i], q[15-i].
- Bypass: q4=0x1111_1111, same cycle wr_en=1, wr_sel=4, wr_data=0x2222_2222, rs=rt=4 -> with REG_READ_BYPASS_EN both 0x22222222; without it both 0x11111111.
- Simultaneous accept/pop at count=1 -> count stays 1, response order preserved.
